// File: rtl/drums_pkg.sv
// Shared types and helpers for the drums-hero gameplay core.
// Lane count, counter widths, FSM encoding and a 5-lane popcount.
package drums_pkg;
   localparam int LANES   = 5;
   localparam int SCORE_W = 10;
   localparam int COMBO_W = 6;
   localparam int MISS_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   function automatic logic [2:0] popcount5(input logic [LANES-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction
endpackage

// File: rtl/note_track_tick_gen.sv
// Scroll-step divider and spawn counter for note_track.
// tick is a one-cycle strobe every TICK_DIV enabled cycles; spawn marks every SPAWN_EVERY-th tick.
module tick_gen #(
   parameter int TICK_DIV    = 25_000_000,
   parameter int SPAWN_EVERY = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick,
   output logic spawn
);
   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;

   logic [DW-1:0] div_q, div_d;
   logic [SW-1:0] spc_q, spc_d;

   assign tick  = en && (div_q == DW'(TICK_DIV - 1));
   assign spawn = tick && (spc_q == '0);

   always_comb begin
      div_d = div_q;
      spc_d = spc_q;
      if (clr) begin
         div_d = '0;
         spc_d = '0;
      end else if (en) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) spc_d = (spc_q == SW'(SPAWN_EVERY - 1)) ? '0 : spc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         spc_q <= '0;
      end else begin
         div_q <= div_d;
         spc_q <= spc_d;
      end
   end
endmodule

// File: rtl/note_track.sv
// Drums-hero gameplay core: scrolling note field, pad judging against the bottom row,
// saturating score/combo/miss counters and the IDLE/RUN/OVER game FSM.
module note_track
   import drums_pkg::*;
#(
   parameter int ROWS        = 8,
   parameter int TICK_DIV    = 25_000_000,
   parameter int SPAWN_EVERY = 2,
   parameter int MAX_MISS    = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LANES-1:0]      random_in,
   input  logic [LANES-1:0]      pads,
   input  logic                  start,
   output logic [LANES*ROWS-1:0] field,
   output logic [SCORE_W-1:0]    score,
   output logic [COMBO_W-1:0]    combo,
   output logic [MISS_W-1:0]     misses,
   output logic                  running,
   output logic                  game_over
);
   state_e state_q, state_d;

   logic [ROWS-1:0][LANES-1:0] field_q, field_d;
   logic [SCORE_W-1:0] score_q, score_d, score_nx;
   logic [COMBO_W-1:0] combo_q, combo_d, combo_nx;
   logic [MISS_W-1:0]  miss_q, miss_d, miss_nx;
   logic               running_q, over_q;

   logic tick, spawn, en, clr;

   assign en  = (state_q == ST_RUN);
   assign clr = start && (state_q != ST_RUN);

   tick_gen #(.TICK_DIV(TICK_DIV), .SPAWN_EVERY(SPAWN_EVERY)) u_tick (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .clr  (clr),
      .tick (tick),
      .spawn(spawn)
   );

   // Judge against the pre-shift bottom row; hit bits are removed before the exit miss count.
   logic [LANES-1:0]   bot, hit, bad, left;
   logic [2:0]         hit_n, miss_n;
   logic [SCORE_W:0]   score_sum;
   logic [COMBO_W:0]   combo_sum;
   logic [MISS_W:0]    miss_sum;

   always_comb begin
      bot       = field_q[ROWS-1];
      hit       = pads & bot;
      bad       = pads & ~bot;
      left      = bot & ~hit;
      hit_n     = popcount5(hit);
      miss_n    = tick ? popcount5(left) : 3'd0;
      score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(hit_n);
      combo_sum = (COMBO_W+1)'(combo_q) + (COMBO_W+1)'(hit_n);
      miss_sum  = (MISS_W+1)'(miss_q) + (MISS_W+1)'(miss_n);
      score_nx  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      combo_nx  = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
      miss_nx   = miss_sum[MISS_W]   ? '1 : miss_sum[MISS_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (miss_nx >= MISS_W'(MAX_MISS)) state_d = ST_OVER;
         ST_OVER: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      field_d = field_q;
      score_d = score_q;
      combo_d = combo_q;
      miss_d  = miss_q;
      case (state_q)
         ST_RUN: begin
            score_d = score_nx;
            if (bad != '0)      combo_d = '0;
            else if (hit != '0) combo_d = combo_nx;
            if (miss_n != 3'd0) combo_d = '0;
            field_d[ROWS-1] = left;
            if (tick) begin
               miss_d     = miss_nx;
               field_d[0] = spawn ? random_in : '0;
               for (int r = 1; r < ROWS; r++) field_d[r] = field_q[r-1];
            end
         end
         default: begin
            if (start) begin
               field_d = '0;
               score_d = '0;
               combo_d = '0;
               miss_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         field_q   <= '0;
         score_q   <= '0;
         combo_q   <= '0;
         miss_q    <= '0;
         running_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         field_q   <= field_d;
         score_q   <= score_d;
         combo_q   <= combo_d;
         miss_q    <= miss_d;
         running_q <= (state_d == ST_RUN);
         over_q    <= (state_d == ST_OVER);
      end
   end

   assign field     = field_q;
   assign score     = score_q;
   assign combo     = combo_q;
   assign misses    = miss_q;
   assign running   = running_q;
   assign game_over = over_q;
endmodule

// File: tb/tb_note_track.sv
// Directed bench for note_track with TICK_DIV=4, SPAWN_EVERY=2, ROWS=8, MAX_MISS=10.
// Inputs change 1 time unit after posedge; outputs are checked at the same point.
module tb_note_track;
   localparam int ROWS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  random_in, pads;
   logic        start;
   logic [39:0] field;
   logic [9:0]  score;
   logic [5:0]  combo;
   logic [3:0]  misses;
   logic        running, game_over;

   int n_chk = 0;
   int n_err = 0;

   note_track #(.ROWS(ROWS), .TICK_DIV(4), .SPAWN_EVERY(2), .MAX_MISS(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .random_in(random_in),
      .pads     (pads),
      .start    (start),
      .field    (field),
      .score    (score),
      .combo    (combo),
      .misses   (misses),
      .running  (running),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int exp_s, exp_c;
      reset = 1'b1; random_in = 5'b10101; pads = '0; start = 1'b0;
      step(2);
      reset = 1'b0;
      step(1);
      chk("rst_field", field, 40'h0);
      chk("rst_score", score, 0);
      chk("rst_combo", combo, 0);
      chk("rst_miss", misses, 0);
      chk("rst_run", running, 0);
      chk("rst_over", game_over, 0);

      // 1: spawn and scroll
      start = 1'b1; step(1); start = 1'b0;
      chk("t1_running", running, 1);
      step(4);
      chk("t1_tick1", field, 40'h15);
      step(4);
      chk("t1_tick2", field, 40'h2A0);
      step(24);
      chk("t1_tick8", field, 40'hA82A0A82A0);

      // 2: partial hit, remaining bit exits as a miss
      pads = 5'b00101; step(1); pads = '0;
      chk("t2_score", score, 2);
      chk("t2_combo", combo, 2);
      chk("t2_bottom", field[39:35], 5'b10000);
      step(3);
      chk("t2_miss", misses, 1);
      chk("t2_combo0", combo, 0);
      chk("t2_score_hold", score, 2);

      // 3: hit in the tick cycle suppresses the miss; bad pad clears combo
      step(4);
      pads = 5'b10100; step(1); pads = '0;
      chk("t3_pre_score", score, 4);
      chk("t3_pre_bottom", field[39:35], 5'b00001);
      step(2);
      pads = 5'b00011; step(1); pads = '0;
      chk("t3_score", score, 5);
      chk("t3_combo", combo, 0);
      chk("t3_miss", misses, 1);
      chk("t3_bottom", field[39:35], 5'b00000);

      // 6: reset mid-run, then idle ignores pads and time
      reset = 1'b1; step(1); reset = 1'b0;
      chk("t6_field", field, 40'h0);
      chk("t6_score", score, 0);
      chk("t6_miss", misses, 0);
      chk("t6_run", running, 0);
      pads = 5'b11111; step(8); pads = '0;
      chk("t6_idle_field", field, 40'h0);
      chk("t6_idle_score", score, 0);
      chk("t6_idle_combo", combo, 0);

      // 4: saturation with continuous correct hits
      random_in = 5'b11111;
      start = 1'b1; step(1); start = 1'b0;
      step(32);
      chk("t4_bottom", field[39:35], 5'b11111);
      for (int i = 1; i <= 210; i++) begin
         pads = 5'b11111; step(1); pads = '0;
         exp_s = (5 * i > 1023) ? 1023 : 5 * i;
         exp_c = (5 * i > 63) ? 63 : 5 * i;
         if (i == 1 || i == 12 || i == 13 || i == 14 || i == 204 || i == 205 || i == 210) begin
            chk($sformatf("t4_score_%0d", i), score, exp_s);
            chk($sformatf("t4_combo_%0d", i), combo, exp_c);
         end
         step(7);
      end
      chk("t4_nomiss", misses, 0);

      // 5: stop hitting; two full rows exit -> game over
      step(4);
      chk("t5_miss5", misses, 5);
      chk("t5_combo0", combo, 0);
      chk("t5_run", running, 1);
      step(4);
      chk("t5_miss5b", misses, 5);
      step(4);
      chk("t5_miss10", misses, 10);
      chk("t5_over", game_over, 1);
      chk("t5_notrun", running, 0);
      chk("t5_field", field, 40'h07C1F07C1F);
      pads = 5'b11111; step(8); pads = '0;
      chk("t5_frozen_field", field, 40'h07C1F07C1F);
      chk("t5_frozen_score", score, 1023);
      chk("t5_frozen_miss", misses, 10);
      start = 1'b1; step(1); start = 1'b0;
      chk("t5_restart_run", running, 1);
      chk("t5_restart_over", game_over, 0);
      chk("t5_restart_score", score, 0);
      chk("t5_restart_miss", misses, 0);
      chk("t5_restart_field", field, 40'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/note_track.md
# note_track

Gameplay core of the drums-hero design. It sits directly downstream of `ListaValores` and consumes its 5-bit `RandomSalida` pattern, one bit per drum lane. It feeds those patterns into a scrolling note field of `ROWS` rows, judges drum-pad hits against the bottom row, and keeps score, combo and miss counts. It ends the game when the miss budget is exhausted.

## Interface

**Parameters**
- `ROWS`, 8: note-field depth. Row 0 is the spawn row; row `ROWS-1` is the hit row.
- `TICK_DIV`, 25_000_000: `clk` cycles per scroll step. Minimum 2.
- `SPAWN_EVERY`, 2: a pattern is spawned on every `SPAWN_EVERY`-th scroll step; all other steps spawn an empty row.
- `MAX_MISS`, 10: miss count that ends the game. Range 1..15.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `random_in`, in, 5: lane pattern, connected to `ListaValores.RandomSalida`. Sampled only on spawn steps.
- `pads`, in, 5: debounced drum pads. Each bit is a one-cycle pulse per strike.
- `start`, in, 1: one-cycle pulse that starts a new game.
- `field`, out, 5*`ROWS`: note field. Bits [5r+4:5r] hold row r.
- `score`, out, 10: hit count, saturates at 1023.
- `combo`, out, 6: consecutive-hit count, saturates at 63.
- `misses`, out, 4: miss count.
- `running`, out, 1: high in RUN.
- `game_over`, out, 1: high in OVER.

## Operation

**States**
- IDLE: `field`, `score`, `combo`, `misses` are held at 0.
- RUN: the field scrolls and hits are judged.
- OVER: all outputs are frozen; pads and ticks are ignored.

**Transitions**
- IDLE → RUN on `start`.
- RUN → OVER when the next value of `misses` is ≥ `MAX_MISS`.
- OVER → RUN on `start`.
- `start` in RUN is ignored.
- Entering RUN clears `field`, `score`, `combo`, `misses`, the divider and the spawn counter.

**Divider and spawn**
- The divider counts 0..`TICK_DIV`-1 in RUN only.
- `tick` asserts on the cycle the divider equals `TICK_DIV`-1.
- The spawn counter counts 0..`SPAWN_EVERY`-1 and advances on `tick`. A tick with the spawn counter at 0 is a spawn step.

**Hit judging**
Evaluated every RUN cycle, against the current bottom row `B`:
- `hit = pads & B`
- `bad = pads & ~B`
- Bits in `hit` are cleared from the bottom row.
- `score += popcount(hit)`, saturating.
- If `hit != 0` and `bad == 0`: `combo += popcount(hit)`, saturating.
- If `bad != 0`: `combo <= 0`, and `score` still takes the hits. `misses` is unchanged.

**Scroll**
On `tick`:
- `row[r] <= row[r-1]` for r ≥ 1.
- `row[0] <= random_in` on spawn steps, otherwise 0.
- Bits remaining in the exiting bottom row, after this cycle's hit clearing, are misses: `misses += popcount`, saturating at 15, and `combo <= 0`.

**Simultaneous events**
- Pad and tick in the same cycle: the hit is judged against the pre-shift bottom row. A hit bit is removed before the miss count, so it is never also counted as a miss.
- Misses and a hit in the same cycle: `combo` ends at 0 (misses win).
- Reset mid-game returns to IDLE with all outputs at 0.

## Timing

- All outputs are registered. Every output resets to 0; reset state is IDLE.
- Pad to score/combo: 1 cycle.
- Tick to `field`/`misses` update: 1 cycle.
- Transition into OVER: on the same edge that registers the final miss.
- A note spawned on tick n reaches the hit row after `ROWS`-1 further ticks. It is judgeable for exactly one scroll period, then exits as a miss on the next tick.
- `random_in` must be stable on the cycle `tick` is high. No handshake with `ListaValores`; the pattern is sampled, never acknowledged.

## Structure

- Shared package `drums_pkg`:
  - `LANES = 5`
  - state encoding `ST_IDLE`, `ST_RUN`, `ST_OVER`
  - a `popcount5` function
  - score, combo and miss width constants
- One sub-module: `tick_gen`, which contains the divider and the spawn counter. Ports: `clk`, `reset`, `en`, `clr`; outputs `tick`, `spawn`.
- Note field, judging and the FSM stay in `note_track`.

## Test plan

All scenarios use `TICK_DIV=4`, `SPAWN_EVERY=2`, `ROWS=8`, `MAX_MISS=10`.

1. Reset, then `start`, with `random_in=5'b10101` held → row 0 = 10101 after the first tick; row 1 = 10101 and row 0 = 00000 after the second.
2. Pattern 10101 in the bottom row, `pads=5'b00101` → `score` +2 and `combo` +2 next cycle, `field` bottom row = 10000. At the next tick, `misses` +1 and `combo` = 0.
3. Bottom row 00001, `pads=5'b00011` in the tick cycle → `score` +1, `combo` = 0, `misses` unchanged (the hit suppresses the miss).
4. Drive `score` to 1023 and `combo` to 63 with continuous correct hits → both saturate and do not wrap; the saturation holds across further hits.
5. `random_in=5'b11111`, no pads → `game_over` rises on the tick where `misses` reaches 10 (two exiting rows); `field` is then frozen. A `start` pulse → RUN with all counters at 0.
6. `reset` asserted mid-RUN with a non-empty field → next cycle: IDLE, all outputs 0. Pads and ticks are ignored until `start`.
